adjacency_counter: RTL and testbench
====================================

# adjacency_counter

Sequential scanner that computes the per-tile neighbour-mine count (0–8) for the whole board after mine placement. It reads the mine bitmap through a one-cycle-latency read port and writes one 4-bit count per tile into the count memory. That count memory is the source of the `count` value fed to the tile glyph/colour mapper during rendering. One start/done handshake runs one full-board pass.

## Interface
- `COLS`, default 16: board width in tiles.
- `ROWS`, default 16: board height in tiles.
- `ADDR_W`, default `$clog2(ROWS*COLS)`: tile address width. Address = `row*COLS + col`.

Ports:
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request a full-board pass; sampled only in IDLE.
- `busy` output 1: high from the cycle after `start` is accepted through the `done` cycle.
- `done` output 1: one-cycle pulse when the last count has been written.
- `rd_en` output 1: mine-map read strobe.
- `rd_addr` output ADDR_W: mine-map read address.
- `rd_data` input 1: mine bit for the address presented on the previous cycle (valid exactly 1 cycle after `rd_en`).
- `wr_en` output 1: count-memory write strobe.
- `wr_addr` output ADDR_W: tile address being written.
- `wr_count` output 4: count written.

## Operation
- **States:** IDLE, SCAN, LAST, WRITE, DONE.
- **IDLE:** `start`=1 → SCAN with tile (r,c)=(0,0), slot k=0, accumulator cleared.
- **SCAN:** 9 cycles per tile, k=0..8. Slot order is fixed:
  - k0..k7 = (−1,−1) (−1,0) (−1,+1) (0,−1) (0,+1) (+1,−1) (+1,0) (+1,+1)
  - k8 = centre (0,0).
  - In-bounds slot: `rd_en`=1, `rd_addr` = neighbour address.
  - Out-of-bounds slot (row/col <0, ≥ROWS, or ≥COLS): `rd_en`=0 and the slot contributes 0. Timing is unchanged, so each tile always takes the same number of cycles.
  - Never present an out-of-range address.
- **Returning data:** a pipelined valid flag tracks each read. `rd_data` returned for k0..k7 adds to a 4-bit accumulator. `rd_data` for k8 is captured as `is_mine`.
- **SCAN k=8 → LAST:** no read is issued in LAST; it absorbs the k8 return.
- **LAST → WRITE:**
  - `wr_en`=1, `wr_addr` = tile address, `wr_count` = accumulator (range 0..8, no overflow possible).
  - Then advance to the next tile: c+1, wrapping to c=0 with r+1.
  - After tile (ROWS−1, COLS−1) → DONE; otherwise → SCAN k=0 with the accumulator cleared.
- **DONE:** `done`=1 for one cycle → IDLE.
- **`start` while not IDLE:** ignored; no restart, no queueing.
- **`start` held high in IDLE after DONE:** begins a new pass.
- **Reset (any state, including mid-scan):** next state IDLE. All outputs 0 (`busy`, `done`, `rd_en`, `wr_en`, `rd_addr`, `wr_addr`, `wr_count`). Pipeline valid flag and accumulator are cleared; no partial write is emitted.

## Timing
- **Start:** `start` sampled high in IDLE at cycle T → first `rd_en` at T+1. `busy`=1 from T+1.
- **Per tile:** 11 cycles (9 SCAN + LAST + WRITE).
- **Tile n:** reads at T+1+11n .. T+9+11n; write at T+11+11n.
- **Done:** pulse at T+1+11·ROWS·COLS. With defaults this is T+2817. `busy` drops at T+2818.
- **Output registering:** all outputs are registered. `wr_*` are valid only while `wr_en`=1; `rd_addr` is valid only while `rd_en`=1. Both hold 0 otherwise.

## Configuration
- **`ADJ_MINE_MARK_EN` defined:** a tile whose `is_mine`=1 is written with `wr_count`=4'hF instead of its neighbour count. The count mapper's default branch then renders it blank. Non-mine tiles are unchanged.
- **`ADJ_MINE_MARK_EN` undefined:** the k8 read still occurs (identical timing), but `is_mine` is ignored. Every tile is written with its neighbour count.

## Test plan
- **All-zero map, defaults:** `start` at T → 256 writes, all `wr_count`=0, addresses 0..255 in order; `done` exactly at T+2817; no `rd_addr` ≥256.
- **Single mine at (5,5), address 85:** addresses 68,69,70,84,86,100,101,102 → 1; all others → 0. Address 85 → 0 without the macro, 4'hF with it.
- **Single mine at (0,0):** addresses 1,16,17 → 1. Tile 0 issues only 4 reads (k4,k6,k7,k8); `rd_en`=0 on the other 5 SCAN cycles.
- **All-ones map, no macro:** corners 0,15,240,255 → 3; other edge tiles → 5; interior → 8. With `ADJ_MINE_MARK_EN`, every tile → 4'hF.
- **`rst` pulsed at T+500 (mid-scan):** next cycle all outputs 0, state IDLE. A new `start` then produces a full, correct 256-write pass from address 0.
- **`start` pulsed at T+100 and T+2000 during a pass:** ignored. Exactly 256 writes and a single `done` at T+2817.

Source files
------------

// File: rtl/adjacency_counter.sv
// Full-board neighbour-mine scanner: 9 reads per tile, one 4-bit count written per tile.
// Optional ADJ_MINE_MARK_EN writes 4'hF for tiles that hold a mine.
module adjacency_counter #(
    parameter int COLS   = 16,
    parameter int ROWS   = 16,
    parameter int ADDR_W = $clog2(ROWS*COLS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [3:0]        wr_count
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [2:0] {IDLE, SCAN, LAST, WRITE, DONE} state_t;

    state_t        state, nstate;
    logic [RW-1:0] r, nr;
    logic [CW-1:0] c, nc;
    logic [3:0]    k, nk;
    logic [3:0]    acc;
    logic          ret_vld, ret_k8;
    logic          last_tile, inb;
    int            dr, dc, nbr_r, nbr_c;

    // Outputs are registered from the next-state view so they line up with the state they describe.
    always_comb begin
        nstate    = state;
        nr        = r;
        nc        = c;
        nk        = k;
        last_tile = (r == RW'(ROWS-1)) && (c == CW'(COLS-1));
        case (state)
            IDLE:  if (start) begin
                       nstate = SCAN;
                       nr     = '0;
                       nc     = '0;
                       nk     = '0;
                   end
            SCAN:  if (k == 4'd8) nstate = LAST;
                   else           nk = k + 4'd1;
            LAST:  nstate = WRITE;
            WRITE: if (last_tile) nstate = DONE;
                   else begin
                       nstate = SCAN;
                       nk     = '0;
                       if (c == CW'(COLS-1)) begin
                           nc = '0;
                           nr = r + RW'(1);
                       end else begin
                           nc = c + CW'(1);
                       end
                   end
            DONE:  nstate = IDLE;
            default: nstate = IDLE;
        endcase

        dr = 0;
        dc = 0;
        case (nk)
            4'd0: begin dr = -1; dc = -1; end
            4'd1: begin dr = -1; dc =  0; end
            4'd2: begin dr = -1; dc =  1; end
            4'd3: begin dr =  0; dc = -1; end
            4'd4: begin dr =  0; dc =  1; end
            4'd5: begin dr =  1; dc = -1; end
            4'd6: begin dr =  1; dc =  0; end
            4'd7: begin dr =  1; dc =  1; end
            default: begin dr = 0; dc = 0; end
        endcase
        nbr_r = int'(nr) + dr;
        nbr_c = int'(nc) + dc;
        inb   = (nstate == SCAN) && (nbr_r >= 0) && (nbr_r < ROWS) &&
                (nbr_c >= 0) && (nbr_c < COLS);
    end

`ifdef ADJ_MINE_MARK_EN
    logic mine_now;
    assign mine_now = ret_vld & ret_k8 & rd_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            r        <= '0;
            c        <= '0;
            k        <= '0;
            acc      <= '0;
            ret_vld  <= 1'b0;
            ret_k8   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_count <= '0;
        end else begin
            state   <= nstate;
            r       <= nr;
            c       <= nc;
            k       <= nk;
            // Return pipe: the flag tracks the read issued last cycle and whether it was the centre.
            ret_vld <= rd_en;
            ret_k8  <= rd_en && (state == SCAN) && (k == 4'd8);
            if ((state == IDLE || state == WRITE) && nstate == SCAN)
                acc <= '0;
            else if (ret_vld && !ret_k8)
                acc <= acc + {3'b000, rd_data};

            busy    <= (nstate != IDLE);
            done    <= (nstate == DONE);
            rd_en   <= inb;
            rd_addr <= inb ? ADDR_W'(nbr_r*COLS + nbr_c) : '0;
            wr_en   <= (nstate == WRITE);
            if (nstate == WRITE) begin
                wr_addr <= ADDR_W'(int'(r)*COLS + int'(c));
`ifdef ADJ_MINE_MARK_EN
                wr_count <= mine_now ? 4'hF : acc;
`else
                wr_count <= acc;
`endif
            end else begin
                wr_addr  <= '0;
                wr_count <= '0;
            end
        end
    end
endmodule

// File: tb/tb_adjacency_counter.sv
// Directed bench for adjacency_counter on a 16x16 board with a behavioural 1-cycle mine RAM.
module tb_adjacency_counter;
    logic       clk = 1'b0;
    logic       rst, start;
    logic       busy, done, rd_en, rd_data, wr_en;
    logic [7:0] rd_addr, wr_addr;
    logic [3:0] wr_count;

    adjacency_counter dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

`ifdef ADJ_MINE_MARK_EN
    localparam int MARK = 1;
`else
    localparam int MARK = 0;
`endif

    logic mem [0:255];
    int   cyc = 0;
    int   p0 = 0;
    int   total = 0, bad = 0;
    int   nwr, order_err, oob, idle_err, done_cnt, done_cyc;
    int   busy_first, busy_last, busy_after;
    logic [3:0] wcnt [0:255];
    logic       rlog_en [0:8];
    logic [7:0] rlog_addr [0:8];

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rd_data <= rd_en ? mem[rd_addr] : 1'b0;
    end

    // Passive monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (wr_en) begin
            if (int'(wr_addr) != nwr) order_err = order_err + 1;
            wcnt[wr_addr] = wr_count;
            nwr = nwr + 1;
        end else if (wr_addr != 8'd0 || wr_count != 4'd0) begin
            idle_err = idle_err + 1;
        end
        if (!rd_en && rd_addr != 8'd0) idle_err = idle_err + 1;
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (cyc >= p0 && cyc <= p0 + 8) begin
            rlog_en[cyc-p0]   = rd_en;
            rlog_addr[cyc-p0] = rd_addr;
        end
        if (cyc == p0)        busy_first = int'(busy);
        if (cyc == p0 + 2816) busy_last  = int'(busy);
        if (cyc == p0 + 2817) busy_after = int'(busy);
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        nwr = 0; order_err = 0; oob = 0; idle_err = 0; done_cnt = 0; done_cyc = -1;
        busy_first = -1; busy_last = -1; busy_after = -1;
        for (int i = 0; i < 256; i++) wcnt[i] = 4'hx;
    endtask

    task automatic set_map(input int kind);
        for (int i = 0; i < 256; i++)
            case (kind)
                1:       mem[i] = (i == 85);
                2:       mem[i] = (i == 0);
                3:       mem[i] = 1'b1;
                default: mem[i] = 1'b0;
            endcase
    endtask

    // Kicks off a pass; p0 is the first cycle after start is accepted (T+1).
    task automatic begin_pass();
        @(negedge clk);
        clear_stats();
        p0    = cyc + 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs the rest of a pass for a fixed cycle budget, optionally re-pulsing start.
    task automatic finish_pass(input int poke_a, input int poke_b);
        while (cyc < p0 + 2830) begin
            start = (cyc - p0 + 1 == poke_a || cyc - p0 + 1 == poke_b);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    function automatic int exp_count(input int kind, input int a);
        int r, c, e;
        r = a / 16;
        c = a % 16;
        case (kind)
            1: if (a == 85) return MARK ? 15 : 0;
               else return (a inside {68, 69, 70, 84, 86, 100, 101, 102}) ? 1 : 0;
            2: if (a == 0) return MARK ? 15 : 0;
               else return (a inside {1, 16, 17}) ? 1 : 0;
            3: begin
                if (MARK) return 15;
                e = int'(r == 0 || r == 15) + int'(c == 0 || c == 15);
                return (e == 2) ? 3 : (e == 1) ? 5 : 8;
            end
            default: return 0;
        endcase
    endfunction

    task automatic check_pass(input string tag, input int kind);
        chk({tag, " writes"}, nwr, 256);
        chk({tag, " order"}, order_err, 0);
        chk({tag, " done_count"}, done_cnt, 1);
        chk({tag, " done_cycle"}, done_cyc - p0, 2816);
        chk({tag, " rd_oob"}, oob, 0);
        chk({tag, " idle_zero"}, idle_err, 0);
        chk({tag, " busy_T+1"}, busy_first, 1);
        chk({tag, " busy_done"}, busy_last, 1);
        chk({tag, " busy_drop"}, busy_after, 0);
        for (int a = 0; a < 256; a++)
            chk($sformatf("%s count[%0d]", tag, a), int'(wcnt[a]), exp_count(kind, a));
    endtask

    always @(negedge clk) if (rd_en && int'(rd_addr) >= 256) oob = oob + 1;

    initial begin
        int snap;
        clear_stats();
        set_map(0);
        rst = 1'b1; start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst rd_en", int'(rd_en), 0);
        chk("rst wr_en", int'(wr_en), 0);
        chk("rst addrs", int'(rd_addr) + int'(wr_addr) + int'(wr_count), 0);
        rst = 1'b0;
        @(negedge clk);

        set_map(0); begin_pass(); finish_pass(-1, -1); check_pass("zero", 0);
        set_map(1); begin_pass(); finish_pass(-1, -1); check_pass("mine85", 1);

        set_map(2); begin_pass(); finish_pass(-1, -1); check_pass("mine0", 2);
        for (int i = 0; i < 9; i++)
            chk($sformatf("mine0 rd_en k%0d", i), int'(rlog_en[i]), int'(i inside {4, 6, 7, 8}));
        chk("mine0 addr k4", int'(rlog_addr[4]), 1);
        chk("mine0 addr k6", int'(rlog_addr[6]), 16);
        chk("mine0 addr k7", int'(rlog_addr[7]), 17);
        chk("mine0 addr k8", int'(rlog_addr[8]), 0);
        chk("mine0 addr k0", int'(rlog_addr[0]), 0);

        set_map(3); begin_pass(); finish_pass(-1, -1); check_pass("ones", 3);

        // Mid-scan reset, then a clean pass.
        set_map(1); begin_pass();
        while (cyc < p0 + 499) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst busy", int'(busy), 0);
        chk("midrst rd_en", int'(rd_en), 0);
        chk("midrst wr_en", int'(wr_en), 0);
        chk("midrst outs", int'(done) + int'(rd_addr) + int'(wr_addr) + int'(wr_count), 0);
        snap = nwr;
        repeat (30) @(negedge clk);
        chk("midrst idle_writes", nwr, snap);
        chk("midrst idle_busy", int'(busy), 0);
        begin_pass(); finish_pass(-1, -1); check_pass("afterrst", 1);

        // Start pulses at T+100 and T+2000 are ignored.
        set_map(0); begin_pass(); finish_pass(100, 2000); check_pass("poke", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
